// File: rtl/overcooked_pkg.sv
// Shared dish codes, serving-space states and frame-count defaults.
// Pure declarations; no logic, no latency.
package overcooked_pkg;

  typedef logic [3:0] dish_t;
  localparam dish_t DISH_NONE = 4'd0;

  typedef enum logic {
    SPACE_EMPTY = 1'b0,
    SPACE_HELD  = 1'b1
  } space_state_t;

  localparam int AGE_W             = 9;
  localparam int REJECT_FRAMES_DEF = 300;
  localparam int RETURN_FRAMES_DEF = 180;
  localparam int MAX_DIRTY_DEF     = 4;

endpackage

// File: rtl/serving_counter_if.sv
// Serving-window bus: player drops, checker view and clears, frame timing, plate station.
// master = players/checker/frame source side, slave = serving_counter.
interface serving_counter_if;
  import overcooked_pkg::*;

  logic             vsync;
  logic             timer_go;
  logic [1:0]       place_valid;
  logic [1:0]       place_space;
  dish_t [1:0]      place_item;
  logic [1:0]       place_ack;
  logic [1:0]       place_nack;
  dish_t [1:0]      check_spaces;
  logic             clear_space0;
  logic             clear_space1;
  logic [1:0]       reject_pulse;
  logic             take_dirty;
  logic             dirty_ack;
  logic [2:0]       dirty_plates;

  modport master (
    output vsync, timer_go, place_valid, place_space, place_item,
           clear_space0, clear_space1, take_dirty,
    input  place_ack, place_nack, check_spaces, reject_pulse, dirty_ack, dirty_plates
  );

  modport slave (
    input  vsync, timer_go, place_valid, place_space, place_item,
           clear_space0, clear_space1, take_dirty,
    output place_ack, place_nack, check_spaces, reject_pulse, dirty_ack, dirty_plates
  );

endinterface

// File: rtl/serving_space.sv
// One serving space: EMPTY/HELD FSM, dish register, age timeout and dirty-plate return timer.
// Item and reject pulse are registered (1 cycle); credit is combinational for the accumulator.
module serving_space
  import overcooked_pkg::*;
#(
  parameter int REJECT_FRAMES = REJECT_FRAMES_DEF,
  parameter int RETURN_FRAMES = RETURN_FRAMES_DEF
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  tick_en,
  input  logic  load,
  input  dish_t load_item,
  input  logic  clear,
  output dish_t item,
  output logic  held,
  output logic  reject_pulse,
  output logic  credit
);

  localparam logic [AGE_W-1:0] REJ_LIM  = AGE_W'(REJECT_FRAMES - 1);
  localparam logic [AGE_W-1:0] RET_LOAD = AGE_W'(RETURN_FRAMES);

  space_state_t     state;
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] ret_timer;
  logic             serve;

  assign held  = (state == SPACE_HELD);
  assign serve = held && clear;
  // A serve while a plate is still in flight hands that plate back now instead of losing it.
  assign credit = serve ? (ret_timer != '0) : (tick_en && ret_timer == AGE_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SPACE_EMPTY;
      item         <= DISH_NONE;
      age          <= '0;
      ret_timer    <= '0;
      reject_pulse <= 1'b0;
    end else begin
      reject_pulse <= 1'b0;
      case (state)
        SPACE_EMPTY: begin
          if (load) begin
            state <= SPACE_HELD;
            item  <= load_item;
            age   <= '0;
          end
        end
        SPACE_HELD: begin
          if (clear) begin
            state <= SPACE_EMPTY;
            item  <= DISH_NONE;
            age   <= '0;
          end else if (tick_en) begin
            if (age >= REJ_LIM) begin
              state        <= SPACE_EMPTY;
              item         <= DISH_NONE;
              age          <= '0;
              reject_pulse <= 1'b1;
            end else begin
              age <= age + AGE_W'(1);
            end
          end
        end
      endcase

      if (serve) begin
        ret_timer <= RET_LOAD;
      end else if (tick_en && ret_timer != '0) begin
        ret_timer <= ret_timer - AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/serving_counter.sv
// Serving window: arbitrates two players onto two spaces, detects frame ticks, counts dirty plates.
// Acks/nacks, dish view and plate count update 1 cycle after the request; refused drops are nacked, never stalled.
module serving_counter
  import overcooked_pkg::*;
#(
  parameter int REJECT_FRAMES = REJECT_FRAMES_DEF,
  parameter int RETURN_FRAMES = RETURN_FRAMES_DEF,
  parameter int MAX_DIRTY     = MAX_DIRTY_DEF
) (
  input  logic              clock,
  input  logic              reset,
  serving_counter_if.slave  bus
);

  localparam logic [2:0] MAX_D = 3'(MAX_DIRTY);

  logic        vsync_q;
  logic        tick_en;
  logic [1:0]  acc;
  logic [1:0]  load;
  dish_t [1:0] load_item;
  dish_t [1:0] item;
  logic [1:0]  held;
  logic [1:0]  credit;
  logic [1:0]  clear;
  logic [1:0]  reject;
  logic [1:0]  ack_q;
  logic [1:0]  nack_q;
  logic [2:0]  dirty;
  logic        dirty_ack_q;
  logic        take_ok;
  logic [3:0]  dirty_sum;
  logic [2:0]  dirty_next;

  assign tick_en = bus.vsync & ~vsync_q & bus.timer_go;
  assign clear   = {bus.clear_space1, bus.clear_space0};

  // Player 0 wins a contested empty space; a space being cleared is still HELD, so its drop is refused.
  always_comb begin
    acc       = '0;
    load      = '0;
    load_item = '0;
    acc[0] = bus.place_valid[0] && (bus.place_item[0] != DISH_NONE) && !held[bus.place_space[0]];
    acc[1] = bus.place_valid[1] && (bus.place_item[1] != DISH_NONE) && !held[bus.place_space[1]]
             && !(acc[0] && bus.place_space[0] == bus.place_space[1]);
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        load[bus.place_space[p]]      = 1'b1;
        load_item[bus.place_space[p]] = bus.place_item[p];
      end
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_space
    serving_space #(
      .REJECT_FRAMES (REJECT_FRAMES),
      .RETURN_FRAMES (RETURN_FRAMES)
    ) u_space (
      .clock        (clock),
      .reset        (reset),
      .tick_en      (tick_en),
      .load         (load[s]),
      .load_item    (load_item[s]),
      .clear        (clear[s]),
      .item         (item[s]),
      .held         (held[s]),
      .reject_pulse (reject[s]),
      .credit       (credit[s])
    );
  end

  always_comb begin
    take_ok    = bus.take_dirty && (dirty != 3'd0);
    dirty_sum  = {1'b0, dirty} + {3'b0, credit[0]} + {3'b0, credit[1]} - {3'b0, take_ok};
    dirty_next = (dirty_sum > {1'b0, MAX_D}) ? MAX_D : dirty_sum[2:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      ack_q       <= '0;
      nack_q      <= '0;
      dirty       <= '0;
      dirty_ack_q <= 1'b0;
    end else begin
      vsync_q     <= bus.vsync;
      ack_q       <= acc;
      nack_q      <= bus.place_valid & ~acc;
      dirty       <= dirty_next;
      dirty_ack_q <= take_ok;
    end
  end

  assign bus.place_ack    = ack_q;
  assign bus.place_nack   = nack_q;
  assign bus.check_spaces = item;
  assign bus.reject_pulse = reject;
  assign bus.dirty_ack    = dirty_ack_q;
  assign bus.dirty_plates = dirty;

endmodule

// File: tb/tb_serving_counter.sv
// Directed bench: bus_a drives a default-frame instance, bus_b a short-frame instance (reject 3, return 1).
module tb_serving_counter;

  logic             clock = 1'b0;
  logic             reset;
  logic             vsync;
  logic             timer_go;
  logic [1:0]       place_valid;
  logic [1:0]       place_space;
  logic [1:0][3:0]  place_item;
  logic             clear_space0;
  logic             clear_space1;
  logic             take_dirty;

  int total = 0;
  int bad   = 0;
  int rej_a0 = 0, rej_a1 = 0, rej_b0 = 0, rej_b1 = 0;

  serving_counter_if bus_a();
  serving_counter_if bus_b();

  assign bus_a.vsync = vsync;         assign bus_b.vsync = vsync;
  assign bus_a.timer_go = timer_go;   assign bus_b.timer_go = timer_go;
  assign bus_a.place_valid = place_valid; assign bus_b.place_valid = place_valid;
  assign bus_a.place_space = place_space; assign bus_b.place_space = place_space;
  assign bus_a.place_item = place_item;   assign bus_b.place_item = place_item;
  assign bus_a.clear_space0 = clear_space0; assign bus_b.clear_space0 = clear_space0;
  assign bus_a.clear_space1 = clear_space1; assign bus_b.clear_space1 = clear_space1;
  assign bus_a.take_dirty = take_dirty;   assign bus_b.take_dirty = take_dirty;

  serving_counter #(.REJECT_FRAMES(300), .RETURN_FRAMES(180), .MAX_DIRTY(4)) u_dut (
    .clock (clock), .reset (reset), .bus (bus_a)
  );

  serving_counter #(.REJECT_FRAMES(3), .RETURN_FRAMES(1), .MAX_DIRTY(4)) u_fast (
    .clock (clock), .reset (reset), .bus (bus_b)
  );

  always #5 clock = ~clock;

  // Reject pulses are counted mid-cycle so one-cycle pulses are never missed between steps.
  always @(negedge clock) begin
    if (bus_a.reject_pulse[0] === 1'b1) rej_a0++;
    if (bus_a.reject_pulse[1] === 1'b1) rej_a1++;
    if (bus_b.reject_pulse[0] === 1'b1) rej_b0++;
    if (bus_b.reject_pulse[1] === 1'b1) rej_b1++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
    end
  endtask

  task automatic drop(input logic [1:0] v, input logic [1:0] sp, input logic [3:0] i1, input logic [3:0] i0);
    place_valid   = v;
    place_space   = sp;
    place_item[1] = i1;
    place_item[0] = i0;
    step();
    place_valid = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus_a.check_spaces !== 8'h00) begin bad++; $display("FAIL reset_check_spaces: got %h want 00", bus_a.check_spaces); end
    total++; if (bus_a.place_ack !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", bus_a.place_ack); end
    total++; if (bus_a.place_nack !== 2'b00) begin bad++; $display("FAIL reset_nack: got %b want 00", bus_a.place_nack); end
    total++; if (bus_a.reject_pulse !== 2'b00) begin bad++; $display("FAIL reset_reject: got %b want 00", bus_a.reject_pulse); end
    total++; if (bus_a.dirty_plates !== 3'd0) begin bad++; $display("FAIL reset_dirty: got %0d want 0", bus_a.dirty_plates); end
    total++; if (bus_a.dirty_ack !== 1'b0) begin bad++; $display("FAIL reset_dirty_ack: got %b want 0", bus_a.dirty_ack); end
  endtask

  task automatic test_drop();
    drop(2'b01, 2'b00, 4'd0, 4'd4);
    total++; if (bus_a.check_spaces[0] !== 4'd4) begin bad++; $display("FAIL drop_item: got %0d want 4", bus_a.check_spaces[0]); end
    total++; if (bus_a.place_ack !== 2'b01) begin bad++; $display("FAIL drop_ack: got %b want 01", bus_a.place_ack); end
    total++; if (bus_a.place_nack !== 2'b00) begin bad++; $display("FAIL drop_nack: got %b want 00", bus_a.place_nack); end
    step();
    total++; if (bus_a.place_ack !== 2'b00) begin bad++; $display("FAIL drop_ack_pulse: got %b want 00", bus_a.place_ack); end
  endtask

  task automatic test_contend();
    drop(2'b11, 2'b11, 4'd5, 4'd2);
    total++; if (bus_a.check_spaces[1] !== 4'd2) begin bad++; $display("FAIL contend_item: got %0d want 2", bus_a.check_spaces[1]); end
    total++; if (bus_a.place_ack !== 2'b01) begin bad++; $display("FAIL contend_ack: got %b want 01", bus_a.place_ack); end
    total++; if (bus_a.place_nack !== 2'b10) begin bad++; $display("FAIL contend_nack: got %b want 10", bus_a.place_nack); end
    total++; if (bus_a.check_spaces[0] !== 4'd4) begin bad++; $display("FAIL contend_other: got %0d want 4", bus_a.check_spaces[0]); end
    drop(2'b10, 2'b10, 4'd7, 4'd0);
    total++; if (bus_a.place_nack !== 2'b10) begin bad++; $display("FAIL drop_on_held: got %b want 10", bus_a.place_nack); end
  endtask

  task automatic test_clear_drop();
    clear_space0 = 1'b1;
    drop(2'b01, 2'b00, 4'd0, 4'd3);
    clear_space0 = 1'b0;
    total++; if (bus_a.check_spaces[0] !== 4'd0) begin bad++; $display("FAIL clear_item: got %0d want 0", bus_a.check_spaces[0]); end
    total++; if (bus_a.place_nack !== 2'b01) begin bad++; $display("FAIL clear_drop_nack: got %b want 01", bus_a.place_nack); end
    total++; if (bus_a.place_ack !== 2'b00) begin bad++; $display("FAIL clear_drop_ack: got %b want 00", bus_a.place_ack); end
    step();
    tick(179);
    total++; if (bus_a.dirty_plates !== 3'd0) begin bad++; $display("FAIL return_early: got %0d want 0", bus_a.dirty_plates); end
    tick(1);
    total++; if (bus_a.dirty_plates !== 3'd1) begin bad++; $display("FAIL return_due: got %0d want 1", bus_a.dirty_plates); end
    total++; if (rej_a1 !== 0) begin bad++; $display("FAIL no_early_reject: got %0d want 0", rej_a1); end
    take_dirty = 1'b1;
    step();
    total++; if (bus_a.dirty_ack !== 1'b1) begin bad++; $display("FAIL take_ack: got %b want 1", bus_a.dirty_ack); end
    total++; if (bus_a.dirty_plates !== 3'd0) begin bad++; $display("FAIL take_count: got %0d want 0", bus_a.dirty_plates); end
    step();
    take_dirty = 1'b0;
    total++; if (bus_a.dirty_ack !== 1'b0) begin bad++; $display("FAIL take_empty_ack: got %b want 0", bus_a.dirty_ack); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drop(2'b01, 2'b00, 4'd0, 4'd7);
    clear_space0 = 1'b1; step(); clear_space0 = 1'b0;
    total++; if (bus_a.dirty_plates !== 3'd0) begin bad++; $display("FAIL b2b_first: got %0d want 0", bus_a.dirty_plates); end
    drop(2'b01, 2'b00, 4'd0, 4'd8);
    total++; if (bus_a.check_spaces[0] !== 4'd8) begin bad++; $display("FAIL b2b_item: got %0d want 8", bus_a.check_spaces[0]); end
    clear_space0 = 1'b1; step(); clear_space0 = 1'b0;
    total++; if (bus_a.dirty_plates !== 3'd1) begin bad++; $display("FAIL b2b_pending_credit: got %0d want 1", bus_a.dirty_plates); end
    drop(2'b11, 2'b10, 4'd9, 4'd1);
    total++; if (bus_a.place_ack !== 2'b11) begin bad++; $display("FAIL split_ack: got %b want 11", bus_a.place_ack); end
    total++; if (bus_a.check_spaces !== {4'd9, 4'd1}) begin bad++; $display("FAIL split_items: got %h want 91", bus_a.check_spaces); end
  endtask

  task automatic test_reject();
    int base;
    do_reset();
    drop(2'b01, 2'b00, 4'd0, 4'd6);
    base = rej_b0;
    tick(2);
    total++; if (bus_b.check_spaces[0] !== 4'd6) begin bad++; $display("FAIL reject_hold: got %0d want 6", bus_b.check_spaces[0]); end
    total++; if (rej_b0 - base !== 0) begin bad++; $display("FAIL reject_early: got %0d want 0", rej_b0 - base); end
    tick(1);
    total++; if (rej_b0 - base !== 1) begin bad++; $display("FAIL reject_once: got %0d want 1", rej_b0 - base); end
    total++; if (bus_b.check_spaces[0] !== 4'd0) begin bad++; $display("FAIL reject_item: got %0d want 0", bus_b.check_spaces[0]); end
    total++; if (bus_b.dirty_plates !== 3'd0) begin bad++; $display("FAIL reject_no_plate: got %0d want 0", bus_b.dirty_plates); end
    drop(2'b01, 2'b00, 4'd0, 4'd9);
    tick(2);
    vsync = 1'b1; clear_space0 = 1'b1; step();
    vsync = 1'b0; clear_space0 = 1'b0; step();
    total++; if (rej_b0 - base !== 1) begin bad++; $display("FAIL clear_beats_timeout: got %0d want 1", rej_b0 - base); end
    total++; if (bus_b.check_spaces[0] !== 4'd0) begin bad++; $display("FAIL clear_timeout_item: got %0d want 0", bus_b.check_spaces[0]); end
    tick(1);
    total++; if (bus_b.dirty_plates !== 3'd1) begin bad++; $display("FAIL clear_timeout_plate: got %0d want 1", bus_b.dirty_plates); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drop(2'b01, 2'b00, 4'd0, 4'd1);
      clear_space0 = 1'b1; step(); clear_space0 = 1'b0;
      tick(1);
    end
    total++; if (bus_b.dirty_plates !== 3'd4) begin bad++; $display("FAIL saturate: got %0d want 4", bus_b.dirty_plates); end
    take_dirty = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (bus_b.dirty_ack !== (k < 4)) begin bad++; $display("FAIL take_ack_%0d: got %b want %b", k, bus_b.dirty_ack, (k < 4)); end
      total++; if (bus_b.dirty_plates !== ((k < 4) ? 3'(3 - k) : 3'd0)) begin bad++; $display("FAIL take_count_%0d: got %0d want %0d", k, bus_b.dirty_plates, (k < 4) ? 3 - k : 0); end
    end
    take_dirty = 1'b0;
    step();
  endtask

  task automatic test_timer_go();
    int base0, base1;
    do_reset();
    timer_go = 1'b0;
    drop(2'b01, 2'b00, 4'd0, 4'd6);
    drop(2'b10, 2'b10, 4'd3, 4'd0);
    total++; if (bus_b.place_ack !== 2'b10) begin bad++; $display("FAIL frozen_drop_ack: got %b want 10", bus_b.place_ack); end
    base0 = rej_b0; base1 = rej_b1;
    tick(100);
    total++; if (rej_b0 - base0 !== 0) begin bad++; $display("FAIL frozen_reject: got %0d want 0", rej_b0 - base0); end
    total++; if (bus_b.check_spaces !== {4'd3, 4'd6}) begin bad++; $display("FAIL frozen_items: got %h want 36", bus_b.check_spaces); end
    timer_go = 1'b1;
    tick(2);
    total++; if (bus_b.check_spaces[0] !== 4'd6) begin bad++; $display("FAIL frozen_age: got %0d want 6", bus_b.check_spaces[0]); end
    tick(1);
    total++; if (rej_b0 - base0 !== 1 || rej_b1 - base1 !== 1) begin bad++; $display("FAIL resume_reject: got %0d/%0d want 1/1", rej_b0 - base0, rej_b1 - base1); end
  endtask

  task automatic test_reset_mid();
    int base0, base1;
    do_reset();
    drop(2'b11, 2'b10, 4'd5, 4'd3);
    clear_space0 = 1'b1; step(); clear_space0 = 1'b0;
    total++; if (bus_a.check_spaces !== {4'd5, 4'd0}) begin bad++; $display("FAIL premid_items: got %h want 50", bus_a.check_spaces); end
    base0 = rej_a0; base1 = rej_a1;
    do_reset();
    total++; if (bus_a.check_spaces !== 8'h00) begin bad++; $display("FAIL mid_items: got %h want 00", bus_a.check_spaces); end
    total++; if ({bus_a.place_ack, bus_a.place_nack, bus_a.reject_pulse, bus_a.dirty_ack} !== 7'd0) begin bad++; $display("FAIL mid_pulses: got %b want 0", {bus_a.place_ack, bus_a.place_nack, bus_a.reject_pulse, bus_a.dirty_ack}); end
    tick(180);
    total++; if (bus_a.dirty_plates !== 3'd0) begin bad++; $display("FAIL mid_return_dropped: got %0d want 0", bus_a.dirty_plates); end
    total++; if (rej_a0 - base0 !== 0 || rej_a1 - base1 !== 0) begin bad++; $display("FAIL mid_no_reject: got %0d/%0d want 0/0", rej_a0 - base0, rej_a1 - base1); end
  endtask

  initial begin
    reset        = 1'b0;
    vsync        = 1'b0;
    timer_go     = 1'b1;
    place_valid  = 2'b00;
    place_space  = 2'b00;
    place_item   = '0;
    clear_space0 = 1'b0;
    clear_space1 = 1'b0;
    take_dirty   = 1'b0;
    step();
    test_reset();
    test_drop();
    test_contend();
    test_clear_drop();
    test_back_to_back();
    test_reject();
    test_saturate();
    test_timer_go();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serving_counter.md
# serving_counter

Serving-window block feeding the order/score checker. It holds the dish each player drops on one of two serving spaces and presents the dish codes on `check_spaces`. It empties a space when the checker pulses `clear_space0`/`clear_space1`, or discards the dish after a frame-based timeout. It returns a dirty plate to the plate station a fixed number of frames after each served dish.

## Interface
Parameters:
- `REJECT_FRAMES`, 300: frames a dish may sit uncleared before it is discarded (5 s at 60 Hz).
- `RETURN_FRAMES`, 180: frames from a served dish to its dirty plate appearing.
- `MAX_DIRTY`, 4: saturation limit of the dirty-plate count.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock, sampled on the rising edge.
- `vsync` in 1: frame strobe level; a frame tick is its rising edge.
- `timer_go` in 1: game running; frame ticks are ignored while low.
- `place_valid` in [1:0]: player p requests a drop this cycle.
- `place_space` in [1:0]: target space for player p (0 or 1).
- `place_item` in [1:0][3:0]: dish code for player p; 0 is invalid.
- `place_ack` out [1:0]: one-cycle pulse when player p's drop was accepted.
- `place_nack` out [1:0]: one-cycle pulse when player p's drop was refused.
- `check_spaces` out [1:0][3:0]: dish code on each space; 0 means empty.
- `clear_space0`, `clear_space1` in 1: checker consumed the dish on space 0 or 1.
- `reject_pulse` out [1:0]: one-cycle pulse when a space's dish times out.
- `take_dirty` in 1: a player picks up a dirty plate.
- `dirty_ack` out 1: one-cycle pulse when a plate was actually taken.
- `dirty_plates` out 3: dirty plates waiting at the station.

## Operation
- Each space has a 2-state FSM, EMPTY and HELD, plus an item register and a 9-bit age counter.
- EMPTY→HELD on an accepted drop. The item register loads the dish code and age clears to 0.
- HELD→EMPTY on that space's clear. The item register clears and the space's return timer loads `RETURN_FRAMES`.
- HELD→EMPTY when age reaches `REJECT_FRAMES` on a tick. The item register clears, `reject_pulse[s]` fires and no plate returns.
- A drop is accepted only if the target space is EMPTY at the start of the cycle and the code is nonzero. All other requests get a nack.
- Both players targeting the same EMPTY space in one cycle: player 0 gets the ack, player 1 gets a nack.
- Players targeting different spaces in one cycle are both serviced independently.
- Clear and drop on the same space in one cycle: the clear is processed and the drop gets a nack.
- Clear on an EMPTY space is ignored.
- A clear and a timeout on the same cycle resolve as a clear: no reject pulse.
- Age increments only on a tick with `timer_go`=1 while HELD. It never exceeds `REJECT_FRAMES`.
- Return timers: each space has a 9-bit down-counter.
  - It decrements on a tick with `timer_go`=1 while nonzero.
  - The transition 1→0 credits one dirty plate.
  - A new serve on a space whose timer is still nonzero credits the pending plate immediately, then reloads the timer.
- `dirty_plates` saturates at `MAX_DIRTY`; excess credits are dropped.
- `take_dirty` with count>0 decrements the count and pulses `dirty_ack`. With count=0 it is ignored, with no ack.
- Same-cycle credits and take net together, up to 2 credits and −1. The result is clamped to 0..`MAX_DIRTY`.

## Timing
- Tick detection: `vsync_q` is a registered copy of `vsync`; tick = `vsync & ~vsync_q`.
- Drop latency: `check_spaces` and `place_ack`/`place_nack` update on the clock edge after `place_valid`, i.e. 1 cycle.
- Clear latency: `check_spaces[s]` reads 0 on the edge after the clear cycle.
  - The checker must pulse clear for exactly one cycle.
  - A second consecutive clear pulse finds the space EMPTY and is ignored.
- A timeout pulses `reject_pulse` on the edge following the tick that reaches the limit.
- Reset values: `check_spaces`=0, both FSMs EMPTY, ages 0, return timers 0, `dirty_plates`=0, all pulse outputs 0, `vsync_q`=0.
- Reset mid-operation discards held dishes and in-flight returns without pulsing anything.
- `timer_go` low freezes all ages and return timers; drops and clears still work.

## Structure
- Shared package `overcooked_pkg`:
  - dish-code typedef (4-bit, with `DISH_NONE`=0);
  - space-state enum (`SPACE_EMPTY`, `SPACE_HELD`);
  - frame-constant defaults.
- Sub-module `serving_space`: one FSM, item register, age counter and return timer; instantiated twice.
- Top-level logic: placement arbitration, tick detection and the dirty-plate accumulator.

## Test plan
- Reset, then player 0 drops code 4 on space 0 → next cycle `check_spaces[0]`=4 and `place_ack`=01.
- Both players drop on EMPTY space 1, codes 2 and 5 → `check_spaces[1]`=2, `place_ack`=01, `place_nack`=10.
- Space 0 holds 4; pulse `clear_space0` with a same-cycle drop of 3 → `check_spaces[0]`=0 and `place_nack`=01. After `RETURN_FRAMES` ticks, `dirty_plates`=1.
- With `REJECT_FRAMES`=3, hold code 6 and give 3 ticks → `reject_pulse[0]` fires once, `check_spaces[0]`=0 and `dirty_plates` is unchanged.
- Serve 5 dishes with `RETURN_FRAMES`=1 → `dirty_plates` saturates at 4. Then take_dirty ×5 → 4 acks, count=0, and the 5th take gives no ack.
- `timer_go`=0 for 100 ticks while HELD → no reject and no age change. Reset mid-HELD → all outputs return to 0 next cycle.
